// File: rtl/game_controller.sv
// SkyHop top-level sequencer: button debounce, game state machine, score and game-over hold.
// Optional SKYHOP_LIVES_EN adds a 2-bit lives counter that lets a failure restart the time bar instead of ending the game.
module game_controller #(
  parameter int DEBOUNCE_MS = 20,
  parameter int GAMEOVER_MS = 3000,
  parameter int MAX_SCORE   = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_ms_tick,
  input  logic       btn,
  input  logic       landed,
  input  logic       fell,
  input  logic       time_elapsed,
  output logic       start_screen_en,
  output logic       time_bar_en,
  output logic       time_bar_start,
  output logic       points_en,
  output logic       points_increase,
  output logic       jump,
  output logic [9:0] score,
  output logic       game_over,
  output logic [2:0] state
`ifdef SKYHOP_LIVES_EN
  ,
  output logic [1:0] lives
`endif
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_LAND  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int            DB_W      = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [15:0]   OVER_LAST = 16'(GAMEOVER_MS - 1);
  localparam logic [9:0]    SCORE_MAX = 10'(MAX_SCORE);

  logic            btn_s1, btn_s2, btn_db, press;
  logic [DB_W-1:0] db_cnt;
  logic [15:0]     over_cnt;
  state_t          cur_state, nxt_state;
  logic            fail, retry;

  // Any cycle where the synchronised level agrees with btn_db restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      press  <= 1'b0;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (one_ms_tick) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_s2;
          db_cnt <= '0;
          press  <= btn_s2;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

  assign fail = fell | time_elapsed;

  always_comb begin
    nxt_state = cur_state;
    retry     = 1'b0;
    case (cur_state)
      S_START: if (press) nxt_state = S_ARM;
      S_ARM:   if (!btn_db) nxt_state = S_PLAY;
      S_PLAY: begin
        if (fail) begin
`ifdef SKYHOP_LIVES_EN
          if (lives > 2'd1) retry = 1'b1;
          else nxt_state = S_OVER;
`else
          nxt_state = S_OVER;
`endif
        end else if (landed) begin
          nxt_state = S_LAND;
        end
      end
      S_LAND:  nxt_state = S_PLAY;
      S_OVER:  if (one_ms_tick && over_cnt == OVER_LAST) nxt_state = S_START;
      default: nxt_state = S_START;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state       <= S_START;
      start_screen_en <= 1'b1;
      time_bar_en     <= 1'b0;
      time_bar_start  <= 1'b0;
      points_en       <= 1'b0;
      points_increase <= 1'b0;
      jump            <= 1'b0;
      score           <= '0;
      game_over       <= 1'b0;
      over_cnt        <= '0;
    end else begin
      cur_state       <= nxt_state;
      start_screen_en <= (nxt_state == S_START);
      time_bar_en     <= (nxt_state == S_PLAY) || (nxt_state == S_LAND);
      points_en       <= (nxt_state == S_PLAY) || (nxt_state == S_LAND) || (nxt_state == S_OVER);
      game_over       <= (nxt_state == S_OVER);
      points_increase <= (nxt_state == S_LAND);
      time_bar_start  <= (cur_state == S_ARM && nxt_state == S_PLAY) || (nxt_state == S_LAND) || retry;
      jump            <= (cur_state == S_PLAY) && press;
      if (cur_state == S_START && nxt_state == S_ARM)
        score <= '0;
      else if (nxt_state == S_LAND)
        score <= (score >= SCORE_MAX) ? SCORE_MAX : score + 10'd1;
      if (nxt_state != S_OVER)
        over_cnt <= '0;
      else if (one_ms_tick)
        over_cnt <= over_cnt + 16'd1;
    end
  end

`ifdef SKYHOP_LIVES_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lives <= 2'd0;
    else if (cur_state == S_START && nxt_state == S_ARM)
      lives <= 2'd3;
    else if (retry)
      lives <= lives - 2'd1;
    else if (cur_state == S_PLAY && fail)
      lives <= 2'd0;
  end
`endif

  assign state = cur_state;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: expected pulses are queued when stimulus is driven and retired by a pulse monitor.
// Also exercises the SKYHOP_LIVES_EN build when that macro is defined.
module tb_game_controller;

  localparam int DEB  = 20;
  localparam int GOMS = 3;
  localparam int MAXS = 6;
  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst, one_ms_tick, btn, landed, fell, time_elapsed;
  logic       start_screen_en, time_bar_en, time_bar_start, points_en;
  logic       points_increase, jump, game_over;
  logic [9:0] score;
  logic [2:0] state;
`ifdef SKYHOP_LIVES_EN
  logic [1:0] lives;
  int         model_lives;
`endif

  int total = 0;
  int bad   = 0;
  int model_score = 0;
  int score_q[$];
  int tbs_q[$];
  int jump_q[$];

  game_controller #(.DEBOUNCE_MS(DEB), .GAMEOVER_MS(GOMS), .MAX_SCORE(MAXS)) dut (
    .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick), .btn(btn), .landed(landed),
    .fell(fell), .time_elapsed(time_elapsed), .start_screen_en(start_screen_en),
    .time_bar_en(time_bar_en), .time_bar_start(time_bar_start), .points_en(points_en),
    .points_increase(points_increase), .jump(jump), .score(score), .game_over(game_over),
    .state(state)
`ifdef SKYHOP_LIVES_EN
    , .lives(lives)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, int'(state), s);
    cycles(1);
  endtask

  task automatic pulse_landed();
    model_score = (model_score + 1 > MAXS) ? MAXS : model_score + 1;
    score_q.push_back(model_score);
    tbs_q.push_back(3);
    landed = 1'b1;
    cycles(1);
    landed = 1'b0;
  endtask

  task automatic start_game();
    btn = 1'b1;
    wait_state(1, (DEB + 6) * TICK, "start_to_arm");
    check_output("score_cleared", int'(score), 0);
    model_score = 0;
    btn = 1'b0;
    tbs_q.push_back(2);
    wait_state(2, (DEB + 6) * TICK, "arm_to_play");
  endtask

  // Tick generator: one-cycle pulse every TICK cycles, free-running through reset.
  initial begin
    one_ms_tick = 1'b0;
    forever begin
      repeat (TICK - 1) @(posedge clk);
      #1 one_ms_tick = 1'b1;
      @(posedge clk);
      #1 one_ms_tick = 1'b0;
    end
  end

  // Pulse monitor retires queued expectations; an unqueued pulse shows up as pending=0.
  always @(negedge clk) begin
    if (rst) begin
      if (points_increase) begin
        check_output("pi_pending", int'(score_q.size() > 0), 1);
        if (score_q.size() > 0) check_output("pi_score", int'(score), score_q.pop_front());
      end
      if (time_bar_start) begin
        check_output("tbs_pending", int'(tbs_q.size() > 0), 1);
        if (tbs_q.size() > 0) check_output("tbs_state", int'(state), tbs_q.pop_front());
      end
      if (jump) begin
        check_output("jump_pending", int'(jump_q.size() > 0), 1);
        if (jump_q.size() > 0) check_output("jump_state", int'(state), jump_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; btn = 1'b0; landed = 1'b0; fell = 1'b0; time_elapsed = 1'b0;
    cycles(5);
    check_output("rst_state", int'(state), 0);
    check_output("rst_sse", int'(start_screen_en), 1);
    check_output("rst_levels", int'({time_bar_en, points_en, game_over}), 0);
    check_output("rst_pulses", int'({jump, points_increase, time_bar_start}), 0);
    check_output("rst_score", int'(score), 0);
    rst = 1'b1;
    cycles(100);
    check_output("idle_state", int'(state), 0);
    check_output("idle_sse", int'(start_screen_en), 1);

    // Bouncing button: never stable long enough, then held high.
    for (int i = 0; i < 5; i++) begin
      btn = ~btn;
      cycles(3 * TICK);
    end
    btn = 1'b1;
    cycles(12 * TICK);
    check_output("no_early_press", int'(state), 0);
    wait_state(1, 13 * TICK, "bounce_arm");
    check_output("arm_score", int'(score), 0);
    btn = 1'b0;
    tbs_q.push_back(2);
    wait_state(2, (DEB + 6) * TICK, "bounce_play");
    check_output("play_levels", int'({start_screen_en, time_bar_en, points_en}), 3);

    for (int i = 0; i < 5; i++) begin
      pulse_landed();
      cycles(10);
    end
    check_output("score_five", int'(score), 5);

    jump_q.push_back(2);
    btn = 1'b1;
    cycles((DEB + 4) * TICK);
    btn = 1'b0;
    cycles((DEB + 4) * TICK);
    check_output("jump_retired", jump_q.size(), 0);

    for (int i = 0; i < 3; i++) begin
      pulse_landed();
      cycles(10);
    end
    check_output("score_saturated", int'(score), MAXS);

    // Failure and landing together: failure wins, no point awarded.
    landed = 1'b1; fell = 1'b1;
    cycles(1);
    landed = 1'b0; fell = 1'b0;
    wait_state(4, 5, "fail_to_over");
    check_output("over_levels", int'({game_over, points_en, time_bar_en}), 6);
    check_output("over_score", int'(score), MAXS);
    cycles(3);
    check_output("over_hold", int'(state), 4);
    wait_state(0, (GOMS + 2) * TICK, "over_to_start");
    check_output("start_levels", int'({start_screen_en, points_en, game_over}), 4);

    start_game();
`ifdef SKYHOP_LIVES_EN
    model_lives = 3;
    check_output("lives_loaded", int'(lives), model_lives);
    for (int e = 0; e < 3; e++) begin
      if (e < 2) tbs_q.push_back(2);
      time_elapsed = 1'b1;
      cycles(1);
      time_elapsed = 1'b0;
      cycles(4);
      model_lives--;
      check_output("lives_dec", int'(lives), model_lives);
      check_output("lives_state", int'(state), (e < 2) ? 2 : 4);
    end
`else
    time_elapsed = 1'b1;
    cycles(1);
    time_elapsed = 1'b0;
    wait_state(4, 5, "elapsed_to_over");
`endif
    wait_state(0, (GOMS + 2) * TICK, "over_to_start2");

    // Reset in the middle of play aborts with no pulse afterwards.
    start_game();
    #3 rst = 1'b0;
    #1;
    check_output("async_rst_state", int'(state), 0);
    check_output("async_rst_sse", int'(start_screen_en), 1);
    check_output("async_rst_score", int'(score), 0);
    cycles(3);
    rst = 1'b1;
    cycles(40);
    check_output("post_rst_state", int'(state), 0);

    check_output("score_q_empty", score_q.size(), 0);
    check_output("tbs_q_empty", tbs_q.size(), 0);
    check_output("jump_q_empty", jump_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
